breadboard_sweeper: RTL and testbench

- Sequential stimulus/capture engine for the 4-input, 10-output combinational logic block used in the ALU path.
- Drives each of the 16 input vectors in ascending order, waits a programmable settle time, and captures the response into an internal 16-entry table.
- The table is read back through a synchronous read port.
- Replaces the delay-based exhaustive sweep with a synthesizable on-chip sweep.

---
 rtl/sweep_pkg.sv | 16 +
 rtl/sweep_table.sv | 34 +++
 rtl/breadboard_sweeper.sv | 132 +++++++++++++
 tb/tb_breadboard_sweeper.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and default sizes for the breadboard sweeper.
package sweep_pkg;

  localparam int DEF_N_IN        = 4;
  localparam int DEF_N_OUT       = 10;
  localparam int DEF_SETTLE      = 3;
  localparam int DEF_TABLE_DEPTH = 2 ** DEF_N_IN;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/sweep_table.sv
// Response table: one write port, one registered read port, async clear.
// A same-cycle read and write to one entry returns the old contents.
module sweep_table #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/breadboard_sweeper.sv
// On-chip exhaustive sweep of a combinational block: drive each input vector,
// settle, capture. Optional macro SWEEP_SIGNATURE_EN adds a rotate-XOR signature.
//
// Handshake: start is a level sampled only in S_IDLE (no queuing); busy is high
// in S_SETTLE/S_CAPTURE; done is a one-cycle pulse in S_DONE right after busy.
module breadboard_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  resp,
  output logic              busy,
  output logic              done,
  input  logic [N_IN-1:0]   rd_addr,
  output sweep_state_e      state_dbg,
  output logic [N_OUT-1:0]  rd_data
`ifdef SWEEP_SIGNATURE_EN
  ,
  output logic [N_OUT-1:0]  sig
`endif
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN-1:0]  IDX_ONE  = N_IN'(1);
  localparam logic [N_IN-1:0]  IDX_LAST = N_IN'((2 ** N_IN) - 1);

  sweep_state_e     state;
  sweep_state_e     state_next;
  logic [N_IN-1:0]  idx;
  logic [CNT_W-1:0] cnt;
  logic             table_we;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_SETTLE;
      S_SETTLE:  if (cnt == '0) state_next = S_CAPTURE;
      S_CAPTURE: state_next = (idx == IDX_LAST) ? S_DONE : S_SETTLE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state == S_SETTLE) || (state == S_CAPTURE);
    done      = (state == S_DONE);
    table_we  = (state == S_CAPTURE);
    state_dbg = state;
  end

  // Vector index, settle counter and driven stimulus; stim only moves when a
  // new vector begins, so it is stable for all SETTLE+1 cycles of a vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      cnt  <= '0;
      stim <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          stim <= '0;
          if (start) begin
            idx <= '0;
            cnt <= CNT_LOAD;
          end
        end
        S_SETTLE: begin
          if (cnt != '0) cnt <= cnt - CNT_ONE;
        end
        S_CAPTURE: begin
          if (idx != IDX_LAST) begin
            idx  <= idx + IDX_ONE;
            stim <= idx + IDX_ONE;
            cnt  <= CNT_LOAD;
          end
        end
        S_DONE: begin
          idx  <= '0;
          stim <= '0;
        end
        default: begin
          stim <= '0;
        end
      endcase
    end
  end

`ifdef SWEEP_SIGNATURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if ((state == S_IDLE) && start) begin
      sig <= '0;
    end else if (state == S_CAPTURE) begin
      sig <= {sig[N_OUT-2:0], sig[N_OUT-1]} ^ resp;
    end
  end
`endif

  sweep_table #(
    .ADDR_W (N_IN),
    .DATA_W (N_OUT)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (table_we),
    .waddr   (idx),
    .wdata   (resp),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Scoreboard bench for breadboard_sweeper: driver pushes expected stim and
// read data into queues, monitors pop and compare when the DUT presents them.
module tb_breadboard_sweeper;
  import sweep_pkg::*;

  localparam int SWEEP_CYCLES = 16 * (DEF_SETTLE + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] stim;
  logic [9:0] resp;
  logic       busy;
  logic       done;
  logic [3:0] rd_addr = 4'd0;
  logic [9:0] rd_data;
  sweep_state_e state_dbg;
`ifdef SWEEP_SIGNATURE_EN
  logic [9:0] sig;
`endif

  // Stand-in for the logic block: hand-chosen response per input vector.
  logic [9:0] golden [16] = '{
    10'h194, 10'h0A5, 10'h13C, 10'h2F1, 10'h07E, 10'h391, 10'h0C3, 10'h25A,
    10'h1E7, 10'h318, 10'h04D, 10'h2B2, 10'h16F, 10'h3A0, 10'h0D9, 10'h266
  };
  logic sig_mode = 1'b0;

  always_comb resp = sig_mode ? 10'h001 : golden[stim];

  breadboard_sweeper dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stim      (stim),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .state_dbg (state_dbg),
    .rd_data   (rd_data)
`ifdef SWEEP_SIGNATURE_EN
    ,
    .sig       (sig)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] stim_q[$];
  logic [9:0] exp_q[$];
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  int   busy_run = 0;
  int   done_count = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rd_vld <= rd_req;

  // Read-port monitor
  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
      else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  // Sweep monitor: stim sequence, busy length, done placement
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) begin
        busy_run++;
        if (stim_q.size() == 0) check("stim_unexpected", 32'(stim), 32'hFFFF_FFFF);
        else check("stim_seq", 32'(stim), 32'(stim_q.pop_front()));
      end
      if (done) begin
        check("busy_len", 32'(busy_run), 32'(SWEEP_CYCLES));
        check("done_after_busy", 32'(prev_busy), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        done_count++;
        busy_run = 0;
      end
      if (prev_done) begin
        check("stim_after_done", 32'(stim), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
      end
    end
    prev_busy = busy;
    prev_done = done;
  end

  // Driver tasks
  task automatic read_table(input bit expect_zero);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      rd_addr = 4'(i);
      rd_req  = 1'b1;
      exp_q.push_back(expect_zero ? 10'h000 : golden[i]);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (2) @(posedge clk);
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_stim_expect();
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < DEF_SETTLE + 1; k++) stim_q.push_back(4'(v));
    end
  endtask

  task automatic wait_done(input int budget, input int base);
    int n;
    n = 0;
    while (done_count == base && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 32'(done_count != base), 32'd1);
  endtask

  // Start a sweep; a nonzero glitch_cycle re-pulses start that many cycles in.
  task automatic run_sweep(input int glitch_cycle);
    int base;
    base = done_count;
    push_stim_expect();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
`ifdef SWEEP_SIGNATURE_EN
    if (sig_mode) check("sig_cleared", 32'(sig), 32'd0);
`endif
    if (glitch_cycle > 0) begin
      repeat (glitch_cycle - 1) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(SWEEP_CYCLES + 20, base);
    repeat (6) @(posedge clk);
    check("single_done", 32'(done_count - base), 32'd1);
    check("stim_queue_drained", 32'(stim_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    logic [9:0] sig_model;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    read_table(1'b1);

    // Full sweep, then spot reads and full table readback
    run_sweep(0);
    read_table(1'b0);

    // start re-pulsed mid-sweep must be ignored
    run_sweep(10);
    read_table(1'b0);

    // Reset at cycle 30 of a sweep
    base = done_count;
    push_stim_expect();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    stim_q.delete();
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_stim", 32'(stim), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (SWEEP_CYCLES + 10) @(posedge clk);
    check("midrst_no_done", 32'(done_count), 32'(base));
    check("midrst_idle", 32'(state_dbg), 32'(S_IDLE));
    read_table(1'b1);

    // Fresh sweep after reset
    run_sweep(0);
    read_table(1'b0);

`ifdef SWEEP_SIGNATURE_EN
    sig_model = 10'h000;
    for (int i = 0; i < 16; i++) sig_model = {sig_model[8:0], sig_model[9]} ^ 10'h001;
    sig_mode = 1'b1;
    run_sweep(0);
    check("sig_final", 32'(sig), 32'(sig_model));
    run_sweep(0);
    check("sig_final_again", 32'(sig), 32'(sig_model));
    sig_mode = 1'b0;
`else
    sig_model = 10'h000;
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
